// File: rtl/cache_req_queue.sv
// FIFO request buffer between the LSU and the cache controller, with synchronous flush.
// Optional same-cycle empty-queue bypass when CACHE_REQQ_BYPASS_EN is defined.
module cache_req_queue #(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_addr,
  input  logic          in_we,
  input  logic [31:0]   in_wdat,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_addr,
  output logic          out_we,
  output logic [31:0]   out_wdat,
  output logic [CW-1:0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [31:0]   addr_mem [DEPTH];
  logic          we_mem   [DEPTH];
  logic [31:0]   wdat_mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [CW-1:0] cnt;

  logic empty;
  logic full;
  logic q_valid;
  logic push;
  logic pop;
  logic bypass;
  logic show_in;

  // Handshakes: a transfer happens on an edge where valid & ready are both 1;
  // a presented packet stays stable until accepted, and ready never waits on valid.
  assign empty    = (cnt == '0);
  assign full     = (cnt == CW'(DEPTH));
  assign in_ready = ~full & ~flush;
  assign q_valid  = ~empty & ~flush;
  assign pop      = q_valid & out_ready;

`ifdef CACHE_REQQ_BYPASS_EN
  // Empty queue forwards the input directly; it is stored only if not consumed.
  assign show_in = empty & in_valid & ~flush;
  assign bypass  = show_in & out_ready;
`else
  assign show_in = 1'b0;
  assign bypass  = 1'b0;
`endif

  assign push      = in_valid & in_ready & ~bypass;
  assign out_valid = q_valid | show_in;
  assign count     = cnt;

  always_comb begin
    out_addr = '0;
    out_we   = 1'b0;
    out_wdat = '0;
    if (show_in) begin
      out_addr = in_addr;
      out_we   = in_we;
      out_wdat = in_wdat;
    end else if (q_valid) begin
      out_addr = addr_mem[rp];
      out_we   = we_mem[rp];
      out_wdat = wdat_mem[rp];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (flush) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is deliberately left unreset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      addr_mem[wp] <= in_addr;
      we_mem[wp]   <= in_we;
      wdat_mem[wp] <= in_wdat;
    end
  end
endmodule

// File: tb/tb_cache_req_queue.sv
// Directed self-checking bench for cache_req_queue (DEPTH = 4); bypass checks follow CACHE_REQQ_BYPASS_EN.
module tb_cache_req_queue;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH + 1);

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_addr;
  logic          in_we;
  logic [31:0]   in_wdat;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_addr;
  logic          out_we;
  logic [31:0]   out_wdat;
  logic [CW-1:0] count;

  logic [64:0] exp_q[$];
  int chk_cnt = 0;
  int pass_cnt = 0;

  cache_req_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_we(in_we), .in_wdat(in_wdat),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_we(out_we), .out_wdat(out_wdat),
    .count(count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
  endtask

  // driver tasks; inputs change 1 time unit after a rising edge, checks 1 unit later
  task automatic drive(input logic v, input logic [31:0] a, input logic w, input logic [31:0] d);
    in_valid = v;
    in_addr  = a;
    in_we    = w;
    in_wdat  = d;
    #1;
  endtask

  // scoreboard: any output handshake seen before the edge is compared with the queue head
  task automatic adv();
    logic [64:0] pkt;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("pop_unexpected", 32'd1, 32'd0);
      end else begin
        pkt = exp_q.pop_front();
        check("pop_addr", out_addr, pkt[64:33]);
        check("pop_we", {31'd0, out_we}, {31'd0, pkt[32]});
        check("pop_wdat", out_wdat, pkt[31:0]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] a, input logic w, input logic [31:0] d);
    exp_q.push_back({a, w, d});
  endtask

  task automatic push_one(input logic [31:0] a, input logic w, input logic [31:0] d);
    drive(1'b1, a, w, d);
    check("push_ready", {31'd0, in_ready}, 32'd1);
    push_exp(a, w, d);
    adv();
  endtask

  task automatic idle_check(input string tag);
    drive(1'b0, 32'd0, 1'b0, 32'd0);
    check({tag, "_count"}, {{(32-CW){1'b0}}, count}, 32'd0);
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_out_addr"}, out_addr, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    in_valid = 1'b0;
    in_addr = '0;
    in_we = 1'b0;
    in_wdat = '0;

    // reset
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_addr", out_addr, 32'd0);
    check("rst_out_we", {31'd0, out_we}, 32'd0);
    check("rst_out_wdat", out_wdat, 32'd0);
    check("rst_count", {{(32-CW){1'b0}}, count}, 32'd0);
    @(posedge clk);
    #1;

    // ordering
    out_ready = 1'b0;
    push_one(32'h1000, 1'b0, 32'hA5A5A5A5);
    push_one(32'h2000, 1'b1, 32'hDEADBEEF);
    push_one(32'h3000, 1'b0, 32'h00000000);
    drive(1'b0, 32'd0, 1'b0, 32'd0);
    check("ord_count3", {{(32-CW){1'b0}}, count}, 32'd3);
    check("ord_head_hold", out_addr, 32'h1000);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("ord_valid", {31'd0, out_valid}, 32'd1);
      adv();
    end
    idle_check("ord_end");

    // full / backpressure
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_one(32'h1000 + 32'(4 * i), i[0], 32'hC0DE0000 + 32'(i));
    drive(1'b1, 32'h1010, 1'b1, 32'hFEEDF00D);
    check("full_count", {{(32-CW){1'b0}}, count}, 32'd4);
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    check("full_head", out_addr, 32'h1000);
    out_ready = 1'b1;
    #1;
    check("full_pop_no_push", {31'd0, in_ready}, 32'd0);
    adv();
    drive(1'b1, 32'h1010, 1'b1, 32'hFEEDF00D);
    check("full_next_ready", {31'd0, in_ready}, 32'd1);
    check("full_next_head", out_addr, 32'h1004);
    push_exp(32'h1010, 1'b1, 32'hFEEDF00D);
    adv();
    drive(1'b0, 32'd0, 1'b0, 32'd0);
    check("full_count3", {{(32-CW){1'b0}}, count}, 32'd3);
    repeat (3) adv();
    idle_check("full_end");

    // wrap and concurrency
    out_ready = 1'b0;
    push_one(32'hF000, 1'b1, 32'h11111111);
    push_one(32'hF004, 1'b0, 32'h22222222);
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 32'(4 * i), i[0], 32'h01010101 * 32'(i));
      check("wrap_count", {{(32-CW){1'b0}}, count}, 32'd2);
      check("wrap_in_ready", {31'd0, in_ready}, 32'd1);
      push_exp(32'(4 * i), i[0], 32'h01010101 * 32'(i));
      adv();
    end
    drive(1'b0, 32'd0, 1'b0, 32'd0);
    check("wrap_count_end", {{(32-CW){1'b0}}, count}, 32'd2);
    repeat (2) adv();
    idle_check("wrap_end");

    // flush
    out_ready = 1'b0;
    push_one(32'h6000, 1'b0, 32'h6);
    push_one(32'h6004, 1'b1, 32'h7);
    push_one(32'h6008, 1'b0, 32'h8);
    out_ready = 1'b1;
    flush = 1'b1;
    drive(1'b1, 32'h7000, 1'b1, 32'h77777777);
    check("flush_in_ready", {31'd0, in_ready}, 32'd0);
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    adv();
    flush = 1'b0;
    exp_q.delete();
    idle_check("flush_after");
    out_ready = 1'b0;
    push_one(32'h4000, 1'b1, 32'h44444444);
    drive(1'b0, 32'd0, 1'b0, 32'd0);
    check("flush_new_head", out_addr, 32'h4000);
    check("flush_new_count", {{(32-CW){1'b0}}, count}, 32'd1);
    out_ready = 1'b1;
    #1;
    adv();
    idle_check("flush_end");

    // bypass (or its absence)
    out_ready = 1'b1;
    drive(1'b1, 32'h5000, 1'b1, 32'h12345678);
    push_exp(32'h5000, 1'b1, 32'h12345678);
`ifdef CACHE_REQQ_BYPASS_EN
    check("byp_out_valid", {31'd0, out_valid}, 32'd1);
    check("byp_out_addr", out_addr, 32'h5000);
    adv();
    idle_check("byp_after");
`else
    check("nobyp_out_valid", {31'd0, out_valid}, 32'd0);
    check("nobyp_in_ready", {31'd0, in_ready}, 32'd1);
    adv();
    drive(1'b0, 32'd0, 1'b0, 32'd0);
    check("nobyp_count1", {{(32-CW){1'b0}}, count}, 32'd1);
    check("nobyp_out_valid_next", {31'd0, out_valid}, 32'd1);
    check("nobyp_out_addr_next", out_addr, 32'h5000);
    adv();
    idle_check("nobyp_after");
`endif

    // reset mid-stream drops queued entries
    out_ready = 1'b0;
    push_one(32'h8000, 1'b0, 32'h1);
    push_one(32'h8004, 1'b1, 32'h2);
    drive(1'b0, 32'd0, 1'b0, 32'd0);
    rst_n = 1'b0;
    adv();
    rst_n = 1'b1;
    exp_q.delete();
    idle_check("midrst");
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
